// File: rtl/alu_op_issuer_pkg.sv
// -----------------------------------------------------------------------------
// alu_op_issuer_pkg
// Shared definitions for the PE ALU operand issuer:
//   - default operand and select widths
//   - ALU select encodings (ALU_Sel values understood by the ALU instance)
// -----------------------------------------------------------------------------
package alu_op_issuer_pkg;

   localparam int ALU_WIDTH_DEF = 32;
   localparam int ALU_SEL_W_DEF = 4;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_MUL  = 4'b0010,
      ALU_DIV  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_ROL  = 4'b0110,
      ALU_ROR  = 4'b0111,
      ALU_AND  = 4'b1000,
      ALU_OR   = 4'b1001,
      ALU_XOR  = 4'b1010,
      ALU_NOR  = 4'b1011,
      ALU_NAND = 4'b1100,
      ALU_XNOR = 4'b1101,
      ALU_SLT  = 4'b1110,
      ALU_SRA  = 4'b1111
   } alu_sel_e;

endpackage

// File: rtl/alu_req_fifo.sv
// -----------------------------------------------------------------------------
// alu_req_fifo
// Synchronous FIFO holding packed ALU requests.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   i_push        write i_wdata at the tail (ignored when full)
//   i_wdata       entry to write
//   i_pop         drop the head entry (ignored when empty)
//   o_rdata       head entry, combinational from storage
//   o_count       number of stored entries, 0..DEPTH
//   o_full        count == DEPTH
//   o_empty       count == 0
// -----------------------------------------------------------------------------
module alu_req_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_push,
   input  logic [DW-1:0]             i_wdata,
   input  logic                      i_pop,
   output logic [DW-1:0]             o_rdata,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic                      o_full,
   output logic                      o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DW-1:0]    r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage needs no reset: the head is only consumed when count says it is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
// Initiator side of the PE ALU operand interface. Tagged requests are queued,
// the queue head drives the combinational ALU, and the ALU result is captured
// into a response register returned over a valid/ready channel.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready = FIFO not full)
//   req_a, req_b, req_sel, req_tag request payload
//   alu_A, alu_B, alu_sel         to ALU, from FIFO head (0 when empty)
//   alu_out, alu_carry, alu_zero  from ALU, same cycle
//   rsp_valid/rsp_ready           response handshake
//   rsp_data/carry/zero/err/tag   registered response
//   busy                          work queued or response pending
//   op_count                      responses accepted since reset
// -----------------------------------------------------------------------------
module alu_op_issuer
   import alu_op_issuer_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEF,
   parameter int SEL_W = ALU_SEL_W_DEF,
   parameter int TAG_W = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [SEL_W-1:0] req_sel,
   input  logic [TAG_W-1:0] req_tag,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [SEL_W-1:0] alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam int ENT_W  = 2*WIDTH + SEL_W + TAG_W;
   localparam int FCNT_W = $clog2(DEPTH) + 1;

   logic [ENT_W-1:0]  w_wdata;
   logic [ENT_W-1:0]  w_head;
   logic [FCNT_W-1:0] w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_slot_free;
   logic              w_div0;
   logic [WIDTH-1:0]  w_head_a;
   logic [WIDTH-1:0]  w_head_b;
   logic [SEL_W-1:0]  w_head_sel;
   logic [TAG_W-1:0]  w_head_tag;

   logic              r_rsp_valid;
   logic [WIDTH-1:0]  r_rsp_data;
   logic              r_rsp_carry;
   logic              r_rsp_zero;
   logic              r_rsp_err;
   logic [TAG_W-1:0]  r_rsp_tag;
   logic [CNT_W-1:0]  r_op_count;

   assign w_wdata = {req_a, req_b, req_sel, req_tag};
   assign {w_head_a, w_head_b, w_head_sel, w_head_tag} = w_head;

   assign req_ready   = !w_full;
   assign w_push      = req_valid && !w_full;
   assign w_slot_free = !r_rsp_valid || rsp_ready;
   // Pop decision uses the pre-edge empty flag, so a request never bypasses the queue.
   assign w_pop       = !w_empty && w_slot_free;
   assign w_div0      = (w_head_sel == SEL_W'(ALU_DIV)) && (w_head_b == '0);

   alu_req_fifo #(
      .DW    (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Stale storage must not reach the ALU when nothing is queued.
   assign alu_A   = w_empty ? '0 : w_head_a;
   assign alu_B   = w_empty ? '0 : w_head_b;
   assign alu_sel = w_empty ? '0 : w_head_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_carry <= 1'b0;
         r_rsp_zero  <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_tag   <= '0;
      end else if (w_pop) begin
         r_rsp_valid <= 1'b1;
         r_rsp_tag   <= w_head_tag;
         if (w_div0) begin
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b1;
            r_rsp_err   <= 1'b1;
         end else begin
            r_rsp_data  <= alu_out;
            r_rsp_carry <= alu_carry;
            r_rsp_zero  <= alu_zero;
            r_rsp_err   <= 1'b0;
         end
      end else if (r_rsp_valid && rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_count <= '0;
      end else if (r_rsp_valid && rsp_ready) begin
         r_op_count <= r_op_count + CNT_W'(1);
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_carry = r_rsp_carry;
   assign rsp_zero  = r_rsp_zero;
   assign rsp_err   = r_rsp_err;
   assign rsp_tag   = r_rsp_tag;
   assign busy      = (w_count != '0) || r_rsp_valid;
   assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;

   localparam int WIDTH = 32;
   localparam int SEL_W = 4;
   localparam int TAG_W = 4;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [SEL_W-1:0] req_sel;
   logic [TAG_W-1:0] req_tag;
   logic [WIDTH-1:0] alu_A;
   logic [WIDTH-1:0] alu_B;
   logic [SEL_W-1:0] alu_sel;
   logic [WIDTH-1:0] alu_out;
   logic             alu_carry;
   logic             alu_zero;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_carry;
   logic             rsp_zero;
   logic             rsp_err;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_op_issuer #(
      .WIDTH (WIDTH), .SEL_W (SEL_W), .TAG_W (TAG_W), .DEPTH (DEPTH), .CNT_W (CNT_W)
   ) dut (
      .clk (clk), .rst (rst),
      .req_valid (req_valid), .req_ready (req_ready),
      .req_a (req_a), .req_b (req_b), .req_sel (req_sel), .req_tag (req_tag),
      .alu_A (alu_A), .alu_B (alu_B), .alu_sel (alu_sel),
      .alu_out (alu_out), .alu_carry (alu_carry), .alu_zero (alu_zero),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
      .rsp_data (rsp_data), .rsp_carry (rsp_carry), .rsp_zero (rsp_zero),
      .rsp_err (rsp_err), .rsp_tag (rsp_tag),
      .busy (busy), .op_count (op_count)
   );

   // Behavioural ALU: returns {carry, zero, out}. Divide by zero yields junk
   // so the issuer's override is visible.
   function automatic logic [WIDTH+1:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                                input logic [3:0] sel);
      logic [32:0] w;
      logic [63:0] t;
      logic [31:0] o;
      logic        c;
      w = '0; t = '0; o = '0; c = 1'b0;
      case (sel)
         4'd0:  begin w = {1'b0, a} + {1'b0, b}; o = w[31:0]; c = w[32]; end
         4'd1:  begin w = {1'b0, a} - {1'b0, b}; o = w[31:0]; c = w[32]; end
         4'd2:  o = a * b;
         4'd3:  if (b == 0) begin o = '1; c = 1'b1; end else o = a / b;
         4'd4:  o = a << b[4:0];
         4'd5:  o = a >> b[4:0];
         4'd6:  begin t = {a, a} << b[4:0]; o = t[63:32]; end
         4'd7:  begin t = {a, a} >> b[4:0]; o = t[31:0]; end
         4'd8:  o = a & b;
         4'd9:  o = a | b;
         4'd10: o = a ^ b;
         4'd11: o = ~(a | b);
         4'd12: o = ~(a & b);
         4'd13: o = ~(a ^ b);
         4'd14: o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: o = 32'($signed(a) >>> b[4:0]);
      endcase
      return {c, (o == 32'd0), o};
   endfunction

   assign {alu_carry, alu_zero, alu_out} = alu_ref(alu_A, alu_B, alu_sel);

   // Expected response {err, carry, zero, data} for a request.
   function automatic logic [WIDTH+2:0] exp_rsp(input logic [31:0] a, input logic [31:0] b,
                                                input logic [3:0] sel);
      if (sel == 4'd3 && b == 32'd0) return {1'b1, 1'b0, 1'b1, 32'd0};
      return {1'b0, alu_ref(a, b, sel)};
   endfunction

   // ---------------- reference model: request queue + one response slot
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  sel;
      logic [3:0]  tag;
   } req_t;

   req_t        m_q[$];
   logic        m_valid;
   logic [34:0] m_rsp;
   logic [3:0]  m_tag;
   int          m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_valid = 1'b0;
         m_rsp   = '0;
         m_tag   = '0;
         m_cnt   = 0;
      end else begin
         automatic bit   acc = m_valid && rsp_ready;
         automatic bit   iss = (m_q.size() > 0) && (!m_valid || rsp_ready);
         automatic bit   psh = req_valid && (m_q.size() < DEPTH);
         automatic req_t h;
         if (acc) m_cnt = (m_cnt + 1) % 65536;
         if (iss) begin
            h       = m_q.pop_front();
            m_rsp   = exp_rsp(h.a, h.b, h.sel);
            m_tag   = h.tag;
            m_valid = 1'b1;
         end else if (acc) begin
            m_valid = 1'b0;
         end
         if (psh) m_q.push_back('{req_a, req_b, req_sel, req_tag});
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_model();
      chk("m_rsp_valid", 64'(rsp_valid), 64'(m_valid));
      chk("m_req_ready", 64'(req_ready), 64'(m_q.size() < DEPTH));
      chk("m_busy", 64'(busy), 64'((m_q.size() != 0) || m_valid));
      chk("m_op_count", 64'(op_count), 64'(m_cnt));
      chk("m_alu_A", 64'(alu_A), 64'((m_q.size() != 0) ? m_q[0].a : 32'd0));
      chk("m_alu_B", 64'(alu_B), 64'((m_q.size() != 0) ? m_q[0].b : 32'd0));
      chk("m_alu_sel", 64'(alu_sel), 64'((m_q.size() != 0) ? m_q[0].sel : 4'd0));
      if (m_valid) begin
         chk("m_rsp_payload", 64'({rsp_err, rsp_carry, rsp_zero, rsp_data}), 64'(m_rsp));
         chk("m_rsp_tag", 64'(rsp_tag), 64'(m_tag));
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic [3:0] tag);
      req_valid = v; req_a = a; req_b = b; req_sel = sel; req_tag = tag;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  sel;
      logic [3:0]  tag;
      logic [31:0] d;
      logic        c;
      logic        z;
      logic        e;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{32'd5,        32'd3,        4'h0, 4'd1,  32'd8,        1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'd5,        32'd3,        4'h1, 4'd2,  32'd2,        1'b0, 1'b0, 1'b0};
      vecs[2] = '{32'd5,        32'd5,        4'h1, 4'd3,  32'd0,        1'b0, 1'b1, 1'b0};
      vecs[3] = '{32'd6,        32'd0,        4'h3, 4'd7,  32'd0,        1'b0, 1'b1, 1'b1};
      vecs[4] = '{32'd6,        32'd2,        4'h3, 4'd8,  32'd3,        1'b0, 1'b0, 1'b0};
      vecs[5] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 4'h8, 4'd9,  32'h00000000, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 4'hA, 4'd10, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{32'hFFFFFFFF, 32'd1,        4'h0, 4'd11, 32'd0,        1'b1, 1'b1, 1'b0};
      vecs[8] = '{32'd3,        32'd5,        4'h1, 4'd12, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{32'h80000000, 32'd4,        4'hF, 4'd13, 32'hF8000000, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      rsp_ready = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd1);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_op_count", 64'(op_count), 64'd0);
      chk("reset_rsp_regs", 64'({rsp_data, rsp_carry, rsp_zero, rsp_err, rsp_tag}), 64'd0);
      chk("reset_alu_drive", 64'({alu_A, alu_sel}), 64'd0);

      // ---- table: one request at a time, consumer always ready
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].tag);
         step();
         req_valid = 1'b0;
         chk("vec_alu_A", 64'(alu_A), 64'(vecs[i].a));
         chk("vec_alu_B", 64'(alu_B), 64'(vecs[i].b));
         chk("vec_alu_sel", 64'(alu_sel), 64'(vecs[i].sel));
         chk("vec_no_bypass", 64'(rsp_valid), 64'd0);
         step();
         chk("vec_rsp_valid", 64'(rsp_valid), 64'd1);
         chk("vec_rsp_data", 64'(rsp_data), 64'(vecs[i].d));
         chk("vec_rsp_flags", 64'({rsp_carry, rsp_zero, rsp_err}),
             64'({vecs[i].c, vecs[i].z, vecs[i].e}));
         chk("vec_rsp_tag", 64'(rsp_tag), 64'(vecs[i].tag));
         step();
         chk("vec_accept", 64'(rsp_valid), 64'd0);
         chk("vec_op_count", 64'(op_count), 64'(i + 1));
      end

      // ---- ordering, back-to-back
      drive(1'b1, 32'd5, 32'd3, 4'h1, 4'd2);
      step();
      drive(1'b1, 32'd5, 32'd5, 4'h1, 4'd3);
      step();
      req_valid = 1'b0;
      chk("ord_first", 64'({rsp_valid, rsp_zero, rsp_tag, rsp_data}), {27'd0, 1'b1, 1'b0, 4'd2, 32'd2});
      step();
      chk("ord_second", 64'({rsp_valid, rsp_zero, rsp_tag, rsp_data}), {27'd0, 1'b1, 1'b1, 4'd3, 32'd0});
      step();
      chk("ord_idle", 64'(rsp_valid), 64'd0);

      // ---- backpressure until full, then drain
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'(i + 1), 32'd10, 4'h0, 4'(i));
         chk("bp_ready_fill", 64'(req_ready), 64'd1);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'd99, 32'd99, 4'h0, 4'd5);
         chk("bp_full", 64'(req_ready), 64'd0);
         chk("bp_hold", 64'({rsp_valid, rsp_tag, rsp_data}), {27'd0, 1'b1, 4'd0, 32'd11});
         chk("bp_head", 64'(alu_A), 64'd2);
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         step();
         chk("drain_rsp", 64'({rsp_valid, rsp_tag, rsp_data}), {27'd0, 1'b1, 4'(k), 32'(k + 11)});
         chk("drain_busy", 64'(busy), 64'd1);
      end
      step();
      chk("drain_done", 64'({rsp_valid, busy}), 64'd0);
      chk("drain_op_count", 64'(op_count), 64'd17);

      // ---- reset mid-operation
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'd1, 32'd1, 4'h0, 4'(i));
         step();
      end
      req_valid = 1'b0;
      chk("pre_rst_state", 64'({rsp_valid, busy}), 64'd3);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_outs", 64'({rsp_valid, busy, rsp_err, rsp_zero, rsp_carry}), 64'd0);
      chk("rst_async_data", 64'({rsp_data, rsp_tag}), 64'd0);
      chk("rst_async_cnt", 64'(op_count), 64'd0);
      chk("rst_async_alu", 64'({alu_A, alu_B}), 64'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rst_release_ready", 64'(req_ready), 64'd1);
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_no_stale", 64'({rsp_valid, busy}), 64'd0);
      end

      // ---- randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         automatic logic [3:0]  sel = 4'($urandom_range(0, 15));
         automatic logic [31:0] b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         drive(1'($urandom_range(0, 2) != 0), $urandom, b, sel, 4'($urandom_range(0, 15)));
         rsp_ready = (n % 150 < 40) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0);
         step();
         cmp_model();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Initiator side of the PE ALU operand interface: accepts tagged operation requests, buffers them, and drives the combinational ALU's A/B/ALU_Sel inputs.
- Captures ALU_Out/CarryOut/Zero into a response register and returns it with the tag over a valid/ready channel.
- Sits between the PE instruction/operand path and the ALU instance, decoupling request arrival from result consumption.

Parameters:
- WIDTH, 32, operand/result width
- SEL_W, 4, ALU select width
- TAG_W, 4, request tag width
- DEPTH, 4, request FIFO entries (power of two, >=2)
- CNT_W, 16, completed-op counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept request
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_sel  in  SEL_W  ALU operation select
- req_tag  in  TAG_W  opaque tag, returned with result
- alu_A  out  WIDTH  to ALU A
- alu_B  out  WIDTH  to ALU B
- alu_sel  out  SEL_W  to ALU ALU_Sel
- alu_out  in  WIDTH  from ALU ALU_Out
- alu_carry  in  1  from ALU CarryOut
- alu_zero  in  1  from ALU Zero
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  WIDTH  captured result
- rsp_carry  out  1  captured CarryOut
- rsp_zero  out  1  captured Zero
- rsp_err  out  1  divide-by-zero flag
- rsp_tag  out  TAG_W  tag of result
- busy  out  1  FIFO non-empty or rsp_valid
- op_count  out  CNT_W  responses accepted since reset

Behaviour:
- Reset (async, immediate): FIFO empty, pointers 0, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=0, rsp_err=0, rsp_tag=0, op_count=0; alu_A/alu_B/alu_sel=0 while FIFO empty; req_ready=1 after reset deasserts.
- Reset mid-operation discards all buffered requests and any pending response; nothing is replayed.
- Request push: on the rising edge where req_valid && req_ready, {a,b,sel,tag} is written at the write pointer.
- req_ready = !full. It depends only on registered state, never on req_valid.
- FIFO keeps count in 0..DEPTH with wrapping pointers. Simultaneous push and pop when full is not possible because req_ready=0. Simultaneous push and pop when empty is not allowed: no bypass, and the pop requires non-empty.
- ALU drive: alu_A/alu_B/alu_sel are combinational from the FIFO head entry, and are 0 when the FIFO is empty. The ALU is purely combinational, so its result is valid in the same cycle.
- slot_free = !rsp_valid || rsp_ready.
- Issue: on an edge where FIFO non-empty && slot_free, the block pops the head and loads the response registers:
  - rsp_data = alu_out, rsp_carry = alu_carry, rsp_zero = alu_zero, rsp_tag = head tag, rsp_err = 0.
  - Divide by zero (head sel==4'b0011 and head b==0): rsp_err=1, rsp_data=0, rsp_carry=0, rsp_zero=1, regardless of ALU output.
  - rsp_valid=1.
- Response accept while the FIFO is empty: on an edge with rsp_valid && rsp_ready && FIFO empty, rsp_valid becomes 0. Data registers hold their last value.
- Back-to-back: with continuous rsp_ready=1, one result per cycle.
- Latency: a request pushed at edge N is at the head at best for cycle N+1 and is registered at edge N+1, so rsp_valid is high from N+1. Minimum latency is 1 cycle, plus queueing.
- Backpressure: while rsp_valid && !rsp_ready, response registers are stable and no pop occurs. The FIFO fills and req_ready drops when count==DEPTH.
- op_count: increments on each rsp_valid && rsp_ready edge, wraps modulo 2^CNT_W.
- busy = (count!=0) || rsp_valid.
- Ordering: responses are returned strictly in request order.

Decomposition:
- Shared package holds the ALU select encodings ALU_ADD=0000 through ALU_SRA=1111, with ALU_DIV=0011 used for the zero check, plus WIDTH/SEL_W defaults.
- One sub-module: alu_req_fifo (parameterised synchronous FIFO, async active-high reset, count/full/empty outputs).
- The issuer instantiates the FIFO and contains the response register and counter.

Test Plan:
- Add: push a=5, b=3, sel=0000, tag=1; rsp_ready=1 -> rsp_valid at next edge, rsp_data=8, rsp_zero=0, rsp_err=0, rsp_tag=1, op_count=1.
- Zero flag and ordering: push SUB 5-3 (tag 2) then SUB 5-5 (tag 3) on consecutive cycles -> responses in order: data 2 with zero=0, then data 0 with zero=1; one per cycle.
- Divide by zero: push a=6, b=0, sel=0011, tag=7 -> rsp_err=1, rsp_data=0, rsp_zero=1, rsp_tag=7. Then push a=6, b=2, DIV -> rsp_data=3, rsp_err=0.
- Backpressure/full: hold rsp_ready=0 and push DEPTH+1 ops.
  - Expected: first result held stable, with 4 entries queued (DEPTH=4).
  - req_ready=0 after the FIFO fills.
  - Releasing rsp_ready drains all 5 in tag order, one per cycle; busy drops after the last.
- Reset mid-operation: with 3 queued and rsp_valid=1, assert rst between edges -> outputs zero immediately, req_ready=1 after release, no stale response emitted.
- AND/XOR pass-through: a=F0F0F0F0, b=0F0F0F0F, sel=1000 then 1010 -> alu_A/alu_B/alu_sel driven from the head; rsp_data=00000000 (zero=1) then FFFFFFFF.
